// File: rtl/adxl362_spi_responder.sv
// ADXL362-style SPI register responder (mode 0, MSB first) with a small register map,
// a write-strobe side channel and sample loading that is deferred while a transaction runs.
module adxl362_spi_responder #(
  parameter logic [7:0] DEVID_AD = 8'hAD,
  parameter logic [7:0] PARTID   = 8'hF2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  input  logic       sample_valid,
  output logic [7:0] power_ctl,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRdData, StWrData, StIgnore} state_e;

  localparam logic [7:0] CmdRead   = 8'h0B;
  localparam logic [7:0] CmdWrite  = 8'h0A;
  localparam logic [7:0] SoftKey   = 8'h52;
  localparam logic [7:0] FilterRst = 8'h13;

  // Synchronizers and edge-detect history
  logic       sclk_s1, sclk_s2, sclk_d3;
  logic       cs_s1, cs_s2, cs_d3;
  logic       mosi_s1, mosi_s2;
  logic [1:0] settle_q;
  logic       sclk_rise, sclk_fall, cs_fall;

  // Protocol state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_in_q;
  logic       is_read_q;
  logic [7:0] ptr_q;
  logic [7:0] out_sr_q;
  logic       miso_q;

  // Register file
  logic [7:0] intmap1_q, intmap2_q, filter_ctl_q, power_ctl_q;
  logic [7:0] xdata_q, ydata_q, zdata_q;
  logic       pend_q;
  logic [7:0] pend_x_q, pend_y_q, pend_z_q;
  logic       soft_rst_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q, wr_data_q;

  // Decoded control
  logic       active, byte_done, cmd_done, addr_done, rd_done, wr_done;
  logic       rd_load, wr_hit;
  logic [7:0] rx_byte, rd_addr, rd_val;

  assign sclk_rise = sclk_s2 & ~sclk_d3;
  assign sclk_fall = ~sclk_s2 & sclk_d3;
  // Edges are only trusted once cs_d3 holds a real sample, so a CS held low through
  // reset release is not mistaken for a fresh falling edge.
  assign cs_fall   = cs_d3 & ~cs_s2 & (settle_q == 2'd3);
  assign rx_byte   = {shift_in_q, mosi_s2};

  assign busy      = ~cs_s2;
  assign MISO      = miso_q;
  assign power_ctl = power_ctl_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_d3  <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_d3    <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      sclk_s1  <= SCLK;
      sclk_s2  <= sclk_s1;
      sclk_d3  <= sclk_s2;
      cs_s1    <= CS;
      cs_s2    <= cs_s1;
      cs_d3    <= cs_s2;
      mosi_s1  <= MOSI;
      mosi_s2  <= mosi_s1;
      settle_q <= (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    end
  end

  // Byte-boundary decode and the address the next read snapshot comes from
  always_comb begin
    active    = (state_q != StIdle) && !cs_s2;
    byte_done = active && sclk_rise && (bit_cnt_q == 3'd7);
    cmd_done  = byte_done && (state_q == StCmd);
    addr_done = byte_done && (state_q == StAddr);
    rd_done   = byte_done && (state_q == StRdData);
    wr_done   = byte_done && (state_q == StWrData);
    rd_load   = (addr_done && is_read_q) || rd_done;
    rd_addr   = (state_q == StAddr) ? rx_byte : ptr_q + 8'd1;
    wr_hit    = wr_done && ((ptr_q == 8'h1F) || ((ptr_q >= 8'h2A) && (ptr_q <= 8'h2D)));
  end

  // Register read mux
  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      8'h00:   rd_val = DEVID_AD;
      8'h01:   rd_val = 8'h1D;
      8'h02:   rd_val = PARTID;
      8'h08:   rd_val = xdata_q;
      8'h09:   rd_val = ydata_q;
      8'h0A:   rd_val = zdata_q;
      8'h2A:   rd_val = intmap1_q;
      8'h2B:   rd_val = intmap2_q;
      8'h2C:   rd_val = filter_ctl_q;
      8'h2D:   rd_val = power_ctl_q;
      default: rd_val = 8'h00;
    endcase
  end

  // Next-state logic; CS high forces every state back to idle
  always_comb begin
    state_d = state_q;
    if ((state_q != StIdle) && cs_s2) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (cs_fall) state_d = StCmd;
        StCmd: begin
          if (cmd_done) begin
            state_d = ((rx_byte == CmdRead) || (rx_byte == CmdWrite)) ? StAddr : StIgnore;
          end
        end
        StAddr:  if (addr_done) state_d = is_read_q ? StRdData : StWrData;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Serial datapath: shift-in, pointer, read snapshot and MISO driver
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q  <= 3'd0;
      shift_in_q <= 7'd0;
      is_read_q  <= 1'b0;
      ptr_q      <= 8'h00;
      out_sr_q   <= 8'h00;
      miso_q     <= 1'b0;
    end else begin
      if (!active)        bit_cnt_q <= 3'd0;
      else if (sclk_rise) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (active && sclk_rise) shift_in_q <= rx_byte[6:0];
      if (cmd_done) is_read_q <= (rx_byte == CmdRead);
      if (addr_done)              ptr_q <= rx_byte;
      else if (rd_done || wr_done) ptr_q <= ptr_q + 8'd1;
      if (rd_load) begin
        out_sr_q <= rd_val;
      end else if ((state_q == StRdData) && active && sclk_fall) begin
        out_sr_q <= {out_sr_q[6:0], 1'b0};
      end
      if ((state_q == StRdData) && active) begin
        if (sclk_fall) miso_q <= out_sr_q[7];
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  // Register writes, soft reset, write strobe and sample loading
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      intmap1_q    <= 8'h00;
      intmap2_q    <= 8'h00;
      filter_ctl_q <= FilterRst;
      power_ctl_q  <= 8'h00;
      xdata_q      <= 8'h00;
      ydata_q      <= 8'h00;
      zdata_q      <= 8'h00;
      pend_q       <= 1'b0;
      pend_x_q     <= 8'h00;
      pend_y_q     <= 8'h00;
      pend_z_q     <= 8'h00;
      soft_rst_q   <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 8'h00;
      wr_data_q    <= 8'h00;
    end else begin
      wr_strobe_q <= wr_hit;
      soft_rst_q  <= wr_hit && (ptr_q == 8'h1F) && (rx_byte == SoftKey);
      if (wr_hit) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= rx_byte;
      end
      // Samples arriving mid-transaction wait until CS is high again; latest wins
      if (busy && sample_valid) begin
        pend_q   <= 1'b1;
        pend_x_q <= x_data;
        pend_y_q <= y_data;
        pend_z_q <= z_data;
      end else if (!busy) begin
        pend_q <= 1'b0;
      end
      if (soft_rst_q) begin
        intmap1_q    <= 8'h00;
        intmap2_q    <= 8'h00;
        filter_ctl_q <= FilterRst;
        power_ctl_q  <= 8'h00;
        xdata_q      <= 8'h00;
        ydata_q      <= 8'h00;
        zdata_q      <= 8'h00;
      end else begin
        if (wr_hit) begin
          case (ptr_q)
            8'h2A:   intmap1_q    <= rx_byte;
            8'h2B:   intmap2_q    <= rx_byte;
            8'h2C:   filter_ctl_q <= rx_byte;
            8'h2D:   power_ctl_q  <= rx_byte;
            default: ;
          endcase
        end
        if (!busy && sample_valid) begin
          xdata_q <= x_data;
          ydata_q <= y_data;
          zdata_q <= z_data;
        end else if (!busy && pend_q) begin
          xdata_q <= pend_x_q;
          ydata_q <= pend_y_q;
          zdata_q <= pend_z_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Scoreboard bench for adxl362_spi_responder: stimulus queues expected MISO bytes and
// write strobes; independent monitors pop and compare as the DUT produces them.
module tb_adxl362_spi_responder;

  localparam int Half = 8;  // SCLK half period in clk cycles

  logic       clk, resetn, SCLK, CS, MOSI, MISO, sample_valid;
  logic [7:0] x_data, y_data, z_data, power_ctl, wr_addr, wr_data;
  logic       wr_strobe, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  miso_exp[$];
  logic [15:0] wr_exp[$];
  logic [7:0]  rx_sh;
  int          nb;
  logic [15:0] wr_e;

  adxl362_spi_responder dut (
    .clk          (clk),
    .resetn       (resetn),
    .SCLK         (SCLK),
    .CS           (CS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endfunction

  // MISO monitor: assemble a byte every 8 SCLK rises while CS is low
  always @(posedge SCLK or posedge CS or negedge resetn) begin
    if (CS || !resetn) begin
      nb = 0;
    end else begin
      rx_sh = {rx_sh[6:0], MISO};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (miso_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got %02h expected no byte", rx_sh);
        end else begin
          chk("miso_byte", rx_sh, miso_exp.pop_front());
        end
      end
    end
  end

  // Write-strobe monitor
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_strobe_unexpected: got addr %02h data %02h expected none",
                 wr_addr, wr_data);
      end else begin
        wr_e = wr_exp.pop_front();
        chk("wr_addr", wr_addr, wr_e[15:8]);
        chk("wr_data", wr_data, wr_e[7:0]);
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = b[i];
      repeat (Half) @(negedge clk);
      SCLK = 1'b1;
      repeat (Half) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic tx(input logic [7:0] b, input logic [7:0] exp);
    miso_exp.push_back(exp);
    spi_bits(b, 8);
  endtask

  task automatic cs_low();
    @(negedge clk);
    CS = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (Half) @(negedge clk);
    CS = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge clk);
    x_data = x;
    y_data = y;
    z_data = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d, input bit strobe);
    cs_low();
    tx(8'h0A, 8'h00);
    tx(a, 8'h00);
    if (strobe) wr_exp.push_back({a, d});
    tx(d, 8'h00);
    cs_high();
  endtask

  task automatic read3(input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2);
    cs_low();
    tx(8'h0B, 8'h00);
    tx(a, 8'h00);
    tx(8'h00, e0);
    tx(8'h00, e1);
    tx(8'h00, e2);
    cs_high();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; sample_valid = 1'b0;
    x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_miso", {7'd0, MISO}, 8'h00);
    chk("rst_wr_strobe", {7'd0, wr_strobe}, 8'h00);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_power_ctl", power_ctl, 8'h00);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // ID read, with busy checked mid-transaction
    cs_low();
    chk("busy_cs_low", {7'd0, busy}, 8'h01);
    tx(8'h0B, 8'h00);
    tx(8'h00, 8'h00);
    tx(8'h00, 8'hAD);
    tx(8'h00, 8'h1D);
    tx(8'h00, 8'hF2);
    cs_high();
    chk("busy_cs_high", {7'd0, busy}, 8'h00);

    // Burst read of a sample loaded while idle
    sample(8'h12, 8'h34, 8'h56);
    read3(8'h08, 8'h12, 8'h34, 8'h56);

    // Single write, then read back FILTER_CTL/POWER_CTL
    reg_write(8'h2D, 8'h02, 1'b1);
    chk("power_ctl_w02", power_ctl, 8'h02);
    read3(8'h2C, 8'h13, 8'h02, 8'h00);

    // Pointer wrap 0xFF -> 0x00
    read3(8'hFF, 8'h00, 8'hAD, 8'h1D);

    // Burst write with auto-increment, read-back
    cs_low();
    tx(8'h0A, 8'h00);
    tx(8'h2A, 8'h00);
    wr_exp.push_back(16'h2A55);
    tx(8'h55, 8'h00);
    wr_exp.push_back(16'h2B66);
    tx(8'h66, 8'h00);
    cs_high();
    read3(8'h2A, 8'h55, 8'h66, 8'h13);

    // Read-only write has no effect; non-key write to SOFT_RESET does nothing
    reg_write(8'h00, 8'h99, 1'b0);
    reg_write(8'h1F, 8'h11, 1'b1);
    chk("power_ctl_after_1f11", power_ctl, 8'h02);
    read3(8'h00, 8'hAD, 8'h1D, 8'hF2);

    // Soft reset
    reg_write(8'h1F, 8'h52, 1'b1);
    chk("power_ctl_soft_rst", power_ctl, 8'h00);
    read3(8'h2A, 8'h00, 8'h00, 8'h13);
    read3(8'h08, 8'h00, 8'h00, 8'h00);
    read3(8'h1F, 8'h00, 8'h00, 8'h00);

    // Aborted write: partial data byte
    cs_low();
    tx(8'h0A, 8'h00);
    tx(8'h2B, 8'h00);
    spi_bits(8'hFF, 4);
    cs_high();
    read3(8'h2B, 8'h00, 8'h13, 8'h00);

    // Invalid command
    cs_low();
    tx(8'h0D, 8'h00);
    tx(8'h2D, 8'h00);
    tx(8'h02, 8'h00);
    tx(8'h0B, 8'h00);
    cs_high();
    chk("power_ctl_invalid_cmd", power_ctl, 8'h00);

    // Deferred sample: current read keeps old data, next read sees latest
    sample(8'h21, 8'h22, 8'h23);
    cs_low();
    tx(8'h0B, 8'h00);
    tx(8'h08, 8'h00);
    sample(8'h70, 8'h71, 8'h72);
    sample(8'h77, 8'h88, 8'h99);
    tx(8'h00, 8'h21);
    tx(8'h00, 8'h22);
    tx(8'h00, 8'h23);
    cs_high();
    read3(8'h08, 8'h77, 8'h88, 8'h99);

    // Reset mid-transaction, released with CS still low
    reg_write(8'h2D, 8'h04, 1'b1);
    chk("power_ctl_w04", power_ctl, 8'h04);
    cs_low();
    tx(8'h0A, 8'h00);
    tx(8'h2D, 8'h00);
    spi_bits(8'h02, 3);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_power_ctl", power_ctl, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    chk("midrst_miso", {7'd0, MISO}, 8'h00);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    tx(8'h0A, 8'h00);
    tx(8'h2D, 8'h00);
    tx(8'h09, 8'h00);
    cs_high();
    chk("power_ctl_no_fresh_edge", power_ctl, 8'h00);
    reg_write(8'h2D, 8'h08, 1'b1);
    chk("power_ctl_after_rst", power_ctl, 8'h08);

    repeat (10) @(negedge clk);
    chk("miso_queue_left", 8'(miso_exp.size()), 8'h00);
    chk("wr_queue_left", 8'(wr_exp.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
